// File: rtl/task_dispatcher.sv
// In-order task dispatcher: a small FIFO of 72-bit tasks feeding CLUSTER_NUM
// execution clusters, with per-cluster busy tracking, barriers and error pulses.

module task_dispatcher_lane (
  input  logic clk,
  input  logic rst,
  input  logic i_set,
  input  logic i_done,
  output logic o_busy,
  output logic o_start,
  output logic o_spur
);
  logic r_busy, r_start, r_spur;

  // done clears busy on the same edge; a new start may re-arm it in that edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy  <= 1'b0;
      r_start <= 1'b0;
      r_spur  <= 1'b0;
    end else begin
      r_busy  <= (r_busy & ~i_done) | i_set;
      r_start <= i_set;
      r_spur  <= i_done & ~r_busy & ~r_start;
    end
  end

  assign o_busy  = r_busy;
  assign o_start = r_start;
  assign o_spur  = r_spur;
endmodule

module task_dispatcher #(
  parameter int CLUSTER_NUM    = 7,
  parameter int TASK_BW        = 72,
  parameter int TASK_REDUCE_BW = 68,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        task_valid,
  output logic                        task_ready,
  input  logic [TASK_BW-1:0]          task_in,
  output logic [CLUSTER_NUM-1:0]      exec_start,
  output logic [TASK_REDUCE_BW-1:0]   exec_task,
  input  logic [CLUSTER_NUM-1:0]      exec_op_done,
  output logic [CLUSTER_NUM-1:0]      cluster_busy,
  output logic                        all_idle,
  output logic                        err_bad_id,
  output logic                        err_spur_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]          DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic [3:0]             NUM_ID     = 4'(CLUSTER_NUM);
  localparam logic [3:0]             BARRIER_ID = 4'hF;
  localparam logic [CLUSTER_NUM-1:0] ONE_C      = CLUSTER_NUM'(1);

  logic [TASK_BW-1:0]        r_mem [FIFO_DEPTH];
  logic [AW-1:0]             r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]             r_count;
  logic [TASK_REDUCE_BW-1:0] r_task;
  logic                      r_err_bad, r_all_idle;

  logic                      w_push, w_pop, w_nonempty;
  logic                      w_is_norm, w_is_bar, w_is_bad;
  logic [TASK_BW-1:0]        w_head;
  logic [3:0]                w_id;
  logic [CLUSTER_NUM-1:0]    w_sel, w_busy_post, w_set, w_spur;
  logic [CW-1:0]             w_count_nxt;

  assign task_ready  = ~rst & (r_count < DEPTH_C);
  assign w_push      = task_valid & task_ready;
  assign w_nonempty  = (r_count != '0);
  assign w_head      = r_mem[r_rd_ptr];
  assign w_id        = w_head[TASK_BW-1 -: 4];
  assign w_is_norm   = (w_id < NUM_ID);
  assign w_is_bar    = (w_id == BARRIER_ID);
  assign w_is_bad    = ~w_is_norm & ~w_is_bar;
  assign w_sel       = w_is_norm ? (ONE_C << w_id) : '0;
  // a completion seen this cycle frees the cluster for the head task right away
  assign w_busy_post = cluster_busy & ~exec_op_done;

  always_comb begin
    w_pop = 1'b0;
    if (w_nonempty) begin
      if (w_is_norm)     w_pop = ~|(w_sel & w_busy_post);
      else if (w_is_bar) w_pop = ~|cluster_busy & ~|exec_start;
      else               w_pop = 1'b1;
    end
  end

  assign w_set       = (w_pop & w_is_norm) ? w_sel : '0;
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= task_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_task     <= '0;
      r_err_bad  <= 1'b0;
      r_all_idle <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count   <= w_count_nxt;
      if (w_pop && w_is_norm) r_task <= w_head[TASK_REDUCE_BW-1:0];
      r_err_bad <= w_pop & w_is_bad;
      r_all_idle <= (w_count_nxt == '0) && ((w_busy_post | w_set) == '0) && (w_set == '0);
    end
  end

  for (genvar g = 0; g < CLUSTER_NUM; g++) begin : g_lane
    task_dispatcher_lane u_lane (
      .clk     (clk),
      .rst     (rst),
      .i_set   (w_set[g]),
      .i_done  (exec_op_done[g]),
      .o_busy  (cluster_busy[g]),
      .o_start (exec_start[g]),
      .o_spur  (w_spur[g])
    );
  end

  assign exec_task     = r_task;
  assign err_bad_id    = r_err_bad;
  assign err_spur_done = |w_spur;
  assign all_idle      = r_all_idle;
  assign fifo_count    = r_count;
endmodule

// File: tb/tb_task_dispatcher.sv
// Bench for task_dispatcher: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.

module tb_task_dispatcher;
  localparam int CN = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          task_valid = 1'b0;
  logic [71:0]   task_in = '0;
  logic [CN-1:0] exec_op_done = '0;
  logic          task_ready, all_idle, err_bad_id, err_spur_done;
  logic [CN-1:0] exec_start, cluster_busy;
  logic [67:0]   exec_task;
  logic [3:0]    fifo_count;

  task_dispatcher dut (
    .clk(clk), .rst(rst), .task_valid(task_valid), .task_ready(task_ready),
    .task_in(task_in), .exec_start(exec_start), .exec_task(exec_task),
    .exec_op_done(exec_op_done), .cluster_busy(cluster_busy), .all_idle(all_idle),
    .err_bad_id(err_bad_id), .err_spur_done(err_spur_done), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: tasks waiting in order, which clusters hold work
  logic [71:0]   m_q[$];
  logic [71:0]   m_h;
  logic [CN-1:0] m_busy = '0, m_start = '0, m_nb, m_ns;
  logic [67:0]   m_task = '0;
  logic          m_bad = 1'b0, m_spur = 1'b0, m_idle = 1'b1, m_push;
  int            m_id;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_busy = '0; m_start = '0; m_task = '0;
      m_bad = 1'b0; m_spur = 1'b0; m_idle = 1'b1;
    end else begin
      m_push = task_valid && (m_q.size() < 8);
      m_nb   = m_busy & ~exec_op_done;
      m_ns   = '0;
      m_spur = |(exec_op_done & ~m_busy & ~m_start);
      m_bad  = 1'b0;
      if (m_q.size() > 0) begin
        m_h  = m_q[0];
        m_id = int'(m_h[71:68]);
        if (m_id < CN) begin
          if (!m_nb[m_id]) begin
            m_ns[m_id] = 1'b1;
            m_nb[m_id] = 1'b1;
            m_task = m_h[67:0];
            void'(m_q.pop_front());
          end
        end else if (m_id == 15) begin
          if (m_busy == '0 && m_start == '0) void'(m_q.pop_front());
        end else begin
          m_bad = 1'b1;
          void'(m_q.pop_front());
        end
      end
      if (m_push) m_q.push_back(task_in);
      m_busy  = m_nb;
      m_start = m_ns;
      m_idle  = (m_q.size() == 0) && (m_nb == '0) && (m_ns == '0);
    end
  end

  always @(negedge clk) begin
    check("cmp task_ready", task_ready, !rst && (m_q.size() < 8));
    check("cmp fifo_count", fifo_count, m_q.size());
    check("cmp exec_start", exec_start, m_start);
    check("cmp exec_task", exec_task, m_task);
    check("cmp cluster_busy", cluster_busy, m_busy);
    check("cmp all_idle", all_idle, m_idle);
    check("cmp err_bad_id", err_bad_id, m_bad);
    check("cmp err_spur_done", err_spur_done, m_spur);
  end

  function automatic logic [71:0] mk(input logic [3:0] id, input logic [67:0] p);
    return {id, p};
  endfunction

  task automatic cyc(input logic v, input logic [71:0] t, input logic [CN-1:0] d);
    task_valid = v; task_in = t; exec_op_done = d;
    @(negedge clk);
    task_valid = 1'b0; exec_op_done = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, '0, '0);
  endtask

  initial begin
    #1 rst = 1'b1;
    @(negedge clk); @(negedge clk);
    check("rst ready", task_ready, 0);
    check("rst idle", all_idle, 1);
    check("rst count", fifo_count, 0);
    check("rst busy", cluster_busy, 0);
    rst = 1'b0;

    // single task, cluster 1
    cyc(1'b1, mk(4'd1, 68'h0ABC), '0);
    check("t1 count", fifo_count, 1);
    check("t1 nostart", exec_start, 0);
    idle(1);
    check("t1 start", exec_start, 7'b0000010);
    check("t1 task", exec_task, 68'h0ABC);
    idle(1);
    check("t1 pulse", exec_start, 0);
    check("t1 held", cluster_busy, 7'b0000010);
    check("t1 notidle", all_idle, 0);
    cyc(1'b0, '0, 7'b0000010);
    check("t1 done", cluster_busy, 0);
    check("t1 idle", all_idle, 1);

    // head-of-line stall
    cyc(1'b1, mk(4'd2, 68'hA1), '0);
    cyc(1'b1, mk(4'd2, 68'hA2), '0);
    check("hol start2", exec_start, 7'b0000100);
    check("hol task", exec_task, 68'hA1);
    cyc(1'b1, mk(4'd3, 68'hB3), '0);
    idle(3);
    check("hol nostart", exec_start, 0);
    check("hol count", fifo_count, 2);
    check("hol busy", cluster_busy, 7'b0000100);
    cyc(1'b0, '0, 7'b0000100);
    check("hol restart2", exec_start, 7'b0000100);
    check("hol task2", exec_task, 68'hA2);
    idle(1);
    check("hol start3", exec_start, 7'b0001000);
    check("hol task3", exec_task, 68'hB3);
    cyc(1'b0, '0, 7'b0001100);
    check("hol idle", all_idle, 1);

    // barrier waits for clusters 0 and 1
    cyc(1'b1, mk(4'd0, 68'h10), '0);
    cyc(1'b1, mk(4'd1, 68'h11), '0);
    cyc(1'b1, mk(4'hF, 68'h0), '0);
    cyc(1'b1, mk(4'd4, 68'h14), '0);
    idle(2);
    check("bar busy", cluster_busy, 7'b0000011);
    check("bar count", fifo_count, 2);
    cyc(1'b0, '0, 7'b0000001);
    check("bar busy1", cluster_busy, 7'b0000010);
    check("bar hold", fifo_count, 2);
    cyc(1'b0, '0, 7'b0000010);
    check("bar clear", cluster_busy, 0);
    check("bar nostart", exec_start, 0);
    idle(1);
    check("bar pop", fifo_count, 1);
    check("bar nostart2", exec_start, 0);
    idle(1);
    check("bar start4", exec_start, 7'b0010000);
    check("bar task4", exec_task, 68'h14);
    cyc(1'b0, '0, 7'b0010000);
    check("bar idle", all_idle, 1);

    // full FIFO with every cluster busy
    for (int i = 0; i < 7; i++) cyc(1'b1, mk(4'(i), 68'(100 + i)), '0);
    for (int i = 0; i < 8; i++) cyc(1'b1, mk(4'(i % 7), 68'(200 + i)), '0);
    check("full count", fifo_count, 8);
    check("full ready", task_ready, 0);
    check("full busy", cluster_busy, 7'h7F);
    cyc(1'b1, mk(4'd5, 68'h999), '0);
    check("full refused", fifo_count, 8);
    cyc(1'b0, '0, 7'b0000001);
    check("full ready1", task_ready, 1);
    check("full count7", fifo_count, 7);
    check("full start0", exec_start, 7'b0000001);
    check("full task", exec_task, 68'd200);
    repeat (12) cyc(1'b0, '0, 7'h7F);
    idle(2);
    check("full drained", all_idle, 1);

    // bad id and spurious done
    cyc(1'b1, mk(4'h9, 68'h55), '0);
    check("bad pre", err_bad_id, 0);
    idle(1);
    check("bad pulse", err_bad_id, 1);
    check("bad nostart", exec_start, 0);
    check("bad popped", fifo_count, 0);
    idle(1);
    check("bad once", err_bad_id, 0);
    cyc(1'b0, '0, 7'b0100000);
    check("spur pulse", err_spur_done, 1);
    idle(1);
    check("spur once", err_spur_done, 0);

    // reset in the middle of work
    cyc(1'b1, mk(4'd0, 68'h20), '0);
    cyc(1'b1, mk(4'd1, 68'h21), '0);
    cyc(1'b1, mk(4'd2, 68'h22), '0);
    cyc(1'b1, mk(4'd0, 68'h23), '0);
    cyc(1'b1, mk(4'd3, 68'h24), '0);
    cyc(1'b1, mk(4'd4, 68'h25), '0);
    cyc(1'b1, mk(4'd5, 68'h26), '0);
    check("mid count", fifo_count, 4);
    check("mid busy", cluster_busy, 7'b0000111);
    #2 rst = 1'b1;
    #1;
    check("arst count", fifo_count, 0);
    check("arst busy", cluster_busy, 0);
    check("arst ready", task_ready, 0);
    check("arst idle", all_idle, 1);
    check("arst task", exec_task, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    cyc(1'b1, mk(4'd6, 68'hC0FFEE), '0);
    idle(1);
    check("post start6", exec_start, 7'b1000000);
    check("post task", exec_task, 68'hC0FFEE);
    cyc(1'b0, '0, 7'b1000000);
    check("post idle", all_idle, 1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
